id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the bubble counter.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, decode slot holds a real instruction.
REQ-005 SHALL have port in_ir, input, 8, instruction byte: [7:4] opcode, [3:2] ra, [1:0] rb.
REQ-006 SHALL have port in_ctrl, input, 18, packed decoder outputs {reg_write, dst_reg[1:0], alu_sel[3:0], op2_sel[1:0], wb_sel[1:0], mem_read, mem_write, flag_en, flag_mask[3:0]}, MSB first.
REQ-007 SHALL have port in_opa, input, 8, register-file read data for ra.
REQ-008 SHALL have port in_opb, input, 8, register-file read data for rb.
REQ-009 SHALL have port stall_in, input, 1, downstream hold request.
REQ-010 SHALL have port flush, input, 1, kill decode and EX contents (taken branch / interrupt).
REQ-011 SHALL have port ex_valid, output, 1, EX slot holds a real instruction.
REQ-012 SHALL have port ex_ir, output, 8, registered instruction byte.
REQ-013 SHALL have port ex_ctrl, output, 18, registered control word, same packing as in_ctrl.
REQ-014 SHALL have port ex_opa, output, 8, registered operand A.
REQ-015 SHALL have port ex_opb, output, 8, registered operand B.
REQ-016 SHALL have port id_stall, output, 1, combinational; upstream must hold PC, IR and decode.
REQ-017 SHALL have port bubble_cnt, output, CNT_W, count of load-use bubbles inserted.

Function
REQ-018 SHALL evaluate, per rising edge, priority: reset > flush > stall_in > load-use bubble > normal load.
REQ-019 Normal load SHALL capture in_valid, in_ir, in_ctrl, in_opa, in_opb into the ex_* registers; latency one cycle.
REQ-020 Flush SHALL clear ex_valid, ex_ir, ex_ctrl, ex_opa, ex_opb to zero regardless of stall_in or hazard.
REQ-021 stall_in (without flush) SHALL hold all ex_* registers and bubble_cnt unchanged.
REQ-022 Load-use hazard SHALL be hazard = ex_valid & ex_ctrl.mem_read & ex_ctrl.reg_write & in_valid & (ex_ctrl.dst_reg == in_ir[3:2] | ex_ctrl.dst_reg == in_ir[1:0]).
REQ-023 On hazard (no flush, no stall_in), the stage SHALL load a bubble: ex_valid=0, ex_ir=0, ex_ctrl=0 (alu_sel NOP, no write, no flags), ex_opa=ex_opb=0.
REQ-024 A bubble SHALL last exactly one cycle, since the bubble clears ex_ctrl.mem_read.
REQ-025 id_stall SHALL equal ~flush & (stall_in | hazard).
REQ-026 in_valid=0 SHALL load a bubble through the normal path, with no hazard and no count.
REQ-027 bubble_cnt SHALL increment by 1 on each inserted bubble, saturating at all-ones (no wrap).
REQ-028 Inputs other than in_valid SHALL be ignored for hazard purposes when in_valid=0.

Reset
REQ-029 With rst_n=0 at a rising edge, all ex_* outputs and bubble_cnt SHALL become 0; reset overrides flush and stall_in.
REQ-030 During reset, id_stall SHALL follow REQ-025 using the zeroed registers, giving 0 unless stall_in=1.
REQ-031 Reset asserted mid-stall or mid-bubble SHALL discard held state; the first post-reset load is a normal load.

Configuration
REQ-032 Macro ID_EX_LOAD_USE_EN defined SHALL compile in hazard detection, bubble insertion and bubble_cnt per REQ-022..REQ-027.
REQ-033 Macro ID_EX_LOAD_USE_EN undefined SHALL tie hazard to 0 and bubble_cnt to constant 0, so that id_stall = ~flush & stall_in.

Verification
REQ-034 Load ADD ir=0x26, ctrl with reg_write=1, dst=1, opa=0x05, opb=0x03 -> next cycle ex_valid=1, ex_ir=0x26, ex_opa=0x05, ex_opb=0x03.
REQ-035 EX holds POP R2 (ir=0x76, mem_read=1, reg_write=1, dst=2); decode has ADD R2,R0 (ir=0x28) -> id_stall=1, next ex_valid=0, bubble_cnt=1; following cycle ex_ir=0x28.
REQ-036 Hazard condition plus flush=1 -> id_stall=0, ex_* all zero, bubble_cnt unchanged.
REQ-037 stall_in=1 for 3 cycles with valid EX contents -> ex_* unchanged for 3 cycles, id_stall=1 throughout.
REQ-038 Force 300 load-use hazards with CNT_W=8 -> bubble_cnt=0xFF and holds at 0xFF.
REQ-039 rst_n=0 asserted during a bubble with stall_in=0 -> all outputs 0 next edge; with ID_EX_LOAD_USE_EN undefined, the REQ-035 stimulus gives id_stall=0 and no bubble.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion
// Optional macro ID_EX_LOAD_USE_EN compiles in hazard detection and the bubble counter.
module id_ex_stage #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_ir,
   input  logic [17:0]      in_ctrl,
   input  logic [7:0]       in_opa,
   input  logic [7:0]       in_opb,
   input  logic             stall_in,
   input  logic             flush,
   output logic             ex_valid,
   output logic [7:0]       ex_ir,
   output logic [17:0]      ex_ctrl,
   output logic [7:0]       ex_opa,
   output logic [7:0]       ex_opb,
   output logic             id_stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   // Control word bit positions: {reg_write, dst_reg[1:0], alu_sel, op2_sel, wb_sel, mem_read, ...}
   localparam int REG_WRITE_BIT = 17;
   localparam int DST_HI        = 16;
   localparam int DST_LO        = 15;
   localparam int MEM_READ_BIT  = 6;

   logic hazard;

`ifdef ID_EX_LOAD_USE_EN
   logic [1:0] ex_dst;
   logic [1:0] in_ra;
   logic [1:0] in_rb;

   assign ex_dst = ex_ctrl[DST_HI:DST_LO];
   assign in_ra  = in_ir[3:2];
   assign in_rb  = in_ir[1:0];

   always_comb begin
      hazard = ex_valid & ex_ctrl[MEM_READ_BIT] & ex_ctrl[REG_WRITE_BIT] & in_valid &
               ((ex_dst == in_ra) | (ex_dst == in_rb));
   end

   // Counts only bubbles actually inserted, so flush and stall_in both suppress it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (!flush && !stall_in && hazard && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end
`else
   assign hazard     = 1'b0;
   assign bubble_cnt = '0;
`endif

   assign id_stall = ~flush & (stall_in | hazard);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         ex_valid <= 1'b0;
         ex_ir    <= '0;
         ex_ctrl  <= '0;
         ex_opa   <= '0;
         ex_opb   <= '0;
      end else if (stall_in) begin
         ex_valid <= ex_valid;
         ex_ir    <= ex_ir;
         ex_ctrl  <= ex_ctrl;
         ex_opa   <= ex_opa;
         ex_opb   <= ex_opb;
      end else if (hazard || !in_valid) begin
         // An empty decode slot enters EX as the same all-zero bubble as a load-use stall.
         ex_valid <= 1'b0;
         ex_ir    <= '0;
         ex_ctrl  <= '0;
         ex_opa   <= '0;
         ex_opb   <= '0;
      end else begin
         ex_valid <= 1'b1;
         ex_ir    <= in_ir;
         ex_ctrl  <= in_ctrl;
         ex_opa   <= in_opa;
         ex_opb   <= in_opb;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
// Reference model follows ID_EX_LOAD_USE_EN the same way as the design build.
module tb_id_ex_stage;

   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [17:0] C_RW  = 18'h20000;
   localparam logic [17:0] C_MR  = 18'h00040;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [7:0]       in_ir;
   logic [17:0]      in_ctrl;
   logic [7:0]       in_opa;
   logic [7:0]       in_opb;
   logic             stall_in;
   logic             flush;
   logic             ex_valid;
   logic [7:0]       ex_ir;
   logic [17:0]      ex_ctrl;
   logic [7:0]       ex_opa;
   logic [7:0]       ex_opb;
   logic             id_stall;
   logic [CNT_W-1:0] bubble_cnt;

   int passes = 0;
   int total  = 0;

   // Reference state: what EX should hold, as plain fields.
   bit       m_valid;
   bit [7:0] m_ir;
   bit [17:0] m_ctrl;
   bit [7:0] m_opa;
   bit [7:0] m_opb;
   int       m_cnt;

   always #5 clk = ~clk;

   id_ex_stage #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ir(in_ir), .in_ctrl(in_ctrl),
      .in_opa(in_opa), .in_opb(in_opb), .stall_in(stall_in), .flush(flush),
      .ex_valid(ex_valid), .ex_ir(ex_ir), .ex_ctrl(ex_ctrl), .ex_opa(ex_opa),
      .ex_opb(ex_opb), .id_stall(id_stall), .bubble_cnt(bubble_cnt)
   );

   function automatic logic [17:0] mk_ctrl(bit rw, int dst, bit mr);
      mk_ctrl = (rw ? C_RW : 18'h0) | (18'(dst & 3) << 15) | (mr ? C_MR : 18'h0);
   endfunction

   function automatic bit model_hazard();
`ifdef ID_EX_LOAD_USE_EN
      int dst;
      int ra;
      int rb;
      dst = int'(m_ctrl[16:15]);
      ra  = int'(in_ir) / 4 % 4;
      rb  = int'(in_ir) % 4;
      return m_valid && m_ctrl[6] && m_ctrl[17] && (in_valid === 1'b1) && (dst == ra || dst == rb);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_clear();
      m_valid = 0; m_ir = 0; m_ctrl = 0; m_opa = 0; m_opb = 0;
   endtask

   task automatic model_edge();
      bit hz;
      hz = model_hazard();
      if (!rst_n) begin
         model_clear();
         m_cnt = 0;
      end else if (flush) begin
         model_clear();
      end else if (stall_in) begin
         // EX and the counter keep their values
      end else if (hz) begin
         model_clear();
         if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end else if (in_valid) begin
         m_valid = 1; m_ir = in_ir; m_ctrl = in_ctrl; m_opa = in_opa; m_opb = in_opb;
      end else begin
         model_clear();
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_regs(string tag);
      chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
      chk({tag, ".ex_ir"}, 32'(ex_ir), 32'(m_ir));
      chk({tag, ".ex_ctrl"}, 32'(ex_ctrl), 32'(m_ctrl));
      chk({tag, ".ex_opa"}, 32'(ex_opa), 32'(m_opa));
      chk({tag, ".ex_opb"}, 32'(ex_opb), 32'(m_opb));
      chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(m_cnt));
   endtask

   // Check id_stall against the model, clock once, then check the registered outputs.
   task automatic cyc(string tag);
      bit exp_stall;
      #1;
      exp_stall = !flush && (stall_in || model_hazard());
      chk({tag, ".id_stall"}, 32'(id_stall), 32'(exp_stall));
      @(posedge clk);
      model_edge();
      #1;
      chk_regs(tag);
   endtask

   task automatic drive(bit v, logic [7:0] ir, logic [17:0] ctrl, logic [7:0] a, logic [7:0] b);
      in_valid = v; in_ir = ir; in_ctrl = ctrl; in_opa = a; in_opb = b;
   endtask

   initial begin
      logic [7:0] save_ir;
      rst_n = 0; stall_in = 0; flush = 1;
      drive(1, 8'h76, mk_ctrl(1, 2, 1), 8'hAA, 8'h55);
      model_clear(); m_cnt = 0;
      @(posedge clk); #1;
      cyc("reset_flush");
      stall_in = 1; flush = 0;
      cyc("reset_stall");
      stall_in = 0;
      cyc("reset_plain");
      chk("reset.ex_valid_const", 32'(ex_valid), 32'h0);

      // ADD ir=0x26 with reg_write, dst=1
      rst_n = 1;
      drive(1, 8'h26, mk_ctrl(1, 1, 0), 8'h05, 8'h03);
      cyc("add_load");
      chk("add.ex_ir_const", 32'(ex_ir), 32'h26);
      chk("add.ex_opa_const", 32'(ex_opa), 32'h05);
      chk("add.ex_opb_const", 32'(ex_opb), 32'h03);

      // POP R2 in EX, ADD R2,R0 in decode
      drive(1, 8'h76, mk_ctrl(1, 2, 1), 8'h11, 8'h22);
      cyc("pop_load");
      drive(1, 8'h28, mk_ctrl(1, 0, 0), 8'h33, 8'h44);
`ifdef ID_EX_LOAD_USE_EN
      #1 chk("loaduse.id_stall_const", 32'(id_stall), 32'h1);
      cyc("loaduse_bubble");
      chk("loaduse.ex_valid_const", 32'(ex_valid), 32'h0);
      chk("loaduse.cnt_const", 32'(bubble_cnt), 32'h1);
      cyc("loaduse_after");
      chk("loaduse.ex_ir_const", 32'(ex_ir), 32'h28);
`else
      #1 chk("noluse.id_stall_const", 32'(id_stall), 32'h0);
      cyc("noluse_load");
      chk("noluse.ex_ir_const", 32'(ex_ir), 32'h28);
      chk("noluse.cnt_const", 32'(bubble_cnt), 32'h0);
`endif

      // Hazard together with flush
      drive(1, 8'h76, mk_ctrl(1, 2, 1), 8'h11, 8'h22);
      cyc("pop_load2");
      drive(1, 8'h28, mk_ctrl(1, 0, 0), 8'h33, 8'h44);
      flush = 1;
      #1 chk("flush.id_stall_const", 32'(id_stall), 32'h0);
      cyc("flush_hazard");
      chk("flush.ex_ctrl_const", 32'(ex_ctrl), 32'h0);
      flush = 0;

      // stall_in for three cycles with valid EX contents
      drive(1, 8'h9D, mk_ctrl(1, 3, 0) | 18'h01234, 8'hC3, 8'h3C);
      cyc("pre_stall");
      save_ir = ex_ir;
      stall_in = 1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 8'($urandom), 18'($urandom), 8'($urandom), 8'($urandom));
         #1 chk("stall.id_stall_const", 32'(id_stall), 32'h1);
         cyc("stall_hold");
         chk("stall.ex_ir_held", 32'(ex_ir), 32'(save_ir));
      end
      stall_in = 0;

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst_n    = ($urandom_range(0, 49) != 0);
         flush    = ($urandom_range(0, 11) == 0);
         stall_in = ($urandom_range(0, 4) == 0);
         drive($urandom_range(0, 5) != 0, 8'($urandom),
               mk_ctrl($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1) == 1)
                  | (18'($urandom) & 18'h07FBF),
               8'($urandom), 8'($urandom));
         cyc("random");
      end
      rst_n = 1; flush = 0; stall_in = 0;

`ifdef ID_EX_LOAD_USE_EN
      // Saturation: 300 load-use bubbles from a clean counter
      rst_n = 0;
      cyc("sat_reset");
      rst_n = 1;
      for (int i = 0; i < 300; i++) begin
         drive(1, 8'h76, mk_ctrl(1, 2, 1), 8'(i), 8'h00);
         cyc("sat_pop");
         drive(1, 8'h28, mk_ctrl(1, 0, 0), 8'h01, 8'h02);
         cyc("sat_bubble");
      end
      chk("sat.cnt_const", 32'(bubble_cnt), 32'hFF);
      drive(1, 8'h76, mk_ctrl(1, 2, 1), 8'h00, 8'h00);
      cyc("sat_pop_last");
      drive(1, 8'h28, mk_ctrl(1, 0, 0), 8'h01, 8'h02);
      cyc("sat_hold");
      chk("sat.cnt_hold_const", 32'(bubble_cnt), 32'hFF);
`endif

      // Reset during a bubble, then a normal post-reset load
      drive(1, 8'h76, mk_ctrl(1, 2, 1), 8'h11, 8'h22);
      cyc("rst_pop");
      drive(1, 8'h28, mk_ctrl(1, 0, 0), 8'h33, 8'h44);
      cyc("rst_bubble");
      rst_n = 0;
      cyc("rst_in_bubble");
      chk("rst.ex_ir_const", 32'(ex_ir), 32'h0);
      chk("rst.cnt_const", 32'(bubble_cnt), 32'h0);
      rst_n = 1;
      cyc("rst_first_load");
      chk("rst.first_ir_const", 32'(ex_ir), 32'h28);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
